// File: rtl/func_accel.sv
// Iterative y = a^3 + floor(sqrt(b)) unit with a start/busy handshake: two 8-cycle
// shift-add multiplies, a 4-step restoring sqrt overlapped with the first. Option: FUNC_ACCEL_ZERO_SKIP_EN.
module func_accel (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [23:0] y_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_MUL2,
    S_ADD
`ifdef FUNC_ACCEL_ZERO_SKIP_EN
    , S_SQO
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cnt;
  logic [7:0]  r_a;
  logic [23:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [23:0] r_acc;
  logic [7:0]  r_rad;
  logic [5:0]  r_rem;
  logic [3:0]  r_root;
  logic [23:0] r_y;
  logic        r_busy;

  logic        w_accept;
  logic        w_mul_step;
  logic        w_sqrt_step;
  logic [23:0] w_acc_next;
  logic [7:0]  w_rem_sh;
  logic [7:0]  w_trial;

  assign w_accept   = (r_state == S_IDLE) && start_i;
  assign w_mul_step = (r_state == S_MUL1) || (r_state == S_MUL2);
`ifdef FUNC_ACCEL_ZERO_SKIP_EN
  assign w_sqrt_step = ((r_state == S_MUL1) && !r_cnt[2]) || (r_state == S_SQO);
`else
  assign w_sqrt_step = (r_state == S_MUL1) && !r_cnt[2];
`endif

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 24'd0);

  // Bring down the next radicand bit pair; trial divisor is 4*root + 1.
  assign w_rem_sh = {r_rem, r_rad[7:6]};
  assign w_trial  = {2'b00, r_root, 2'b01};

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: w_next is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
`ifdef FUNC_ACCEL_ZERO_SKIP_EN
          w_next = (a_i == 8'd0) ? S_SQO : S_MUL1;
`else
          w_next = S_MUL1;
`endif
        end
      end
      S_MUL1: if (r_cnt == 3'd7) w_next = S_MUL2;
      S_MUL2: if (r_cnt == 3'd7) w_next = S_ADD;
      S_ADD:  w_next = S_IDLE;
`ifdef FUNC_ACCEL_ZERO_SKIP_EN
      S_SQO:  if (r_cnt == 3'd3) w_next = S_ADD;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: every datapath register is reset so an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_rad    <= '0;
      r_rem    <= '0;
      r_root   <= '0;
      r_y      <= '0;
      r_busy   <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_a      <= a_i;
      r_mcand  <= {16'd0, a_i};
      r_mplier <= a_i;
      r_acc    <= '0;
      r_rad    <= b_i;
      r_rem    <= '0;
      r_root   <= '0;
      r_busy   <= 1'b1;
    end else begin
      if (w_mul_step || w_sqrt_step) begin
        r_cnt <= r_cnt + 3'd1;
      end

      if (w_mul_step) begin
        if ((r_state == S_MUL1) && (r_cnt == 3'd7)) begin
          // a^2 becomes the multiplicand of the second pass, multiplier a again.
          r_acc    <= '0;
          r_mcand  <= w_acc_next;
          r_mplier <= r_a;
        end else begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
        end
      end

      if (w_sqrt_step) begin
        r_rad <= {r_rad[5:0], 2'b00};
        if (w_rem_sh >= w_trial) begin
          r_rem  <= 6'(w_rem_sh - w_trial);
          r_root <= {r_root[2:0], 1'b1};
        end else begin
          r_rem  <= w_rem_sh[5:0];
          r_root <= {r_root[2:0], 1'b0};
        end
      end

      if (r_state == S_ADD) begin
        r_y    <= r_acc + {20'd0, r_root};
        r_busy <= 1'b0;
      end
    end
  end

  assign y_o    = r_y;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_func_accel.sv
// Self-checking bench for func_accel: cycle-level countdown model plus directed
// literal checks and randomized operations with operand/start noise while busy.
module tb_func_accel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic [23:0] y_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  func_accel dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .y_o     (y_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  function automatic int lat(input logic [7:0] a);
`ifdef FUNC_ACCEL_ZERO_SKIP_EN
    return (a == 8'd0) ? 5 : 17;
`else
    return 17;
`endif
  endfunction

  function automatic logic [23:0] ref_y(input int a, input int b);
    int r = 0;
    while ((r + 1) * (r + 1) <= b) r++;
    return 24'(a * a * a + r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted start arms a countdown of the op latency;
  // when it expires the result becomes visible.
  int          m_rem = 0;
  logic [23:0] m_y   = '0;
  logic [7:0]  m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0;
      m_y   = '0;
    end else if (m_rem == 0) begin
      if (start_i === 1'b1) begin
        m_a   = a_i;
        m_b   = b_i;
        m_rem = lat(a_i);
      end
    end else begin
      m_rem--;
      if (m_rem == 0) m_y = ref_y(m_a, m_b);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", {31'd0, busy_o}, {31'd0, (m_rem != 0)});
      check("cyc_y", {8'd0, y_o}, {8'd0, m_y});
    end
  end

  // Called at a negedge; returns at the first negedge with busy low.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit noise, output int len);
    start_i = 1'b1;
    a_i = a;
    b_i = b;
    @(negedge clk);
    start_i = 1'b0;
    len = 0;
    while (busy_o === 1'b1 && len < 40) begin
      len++;
      a_i = 8'($urandom);
      b_i = 8'($urandom);
      if (noise) start_i = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start_i = 1'b0;
    check("busy_len", len, lat(a));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o !== 1'b0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(name, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int len;
    logic [7:0] ra, rb;

    rst_n = 1'b0;
    start_i = 1'b0;
    a_i = '0;
    b_i = '0;
    repeat (3) @(negedge clk);
    check("rst_y", {8'd0, y_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_y", {8'd0, y_o}, 32'd0);
    check("idle_busy", {31'd0, busy_o}, 32'd0);

    run_op(8'd3, 8'd16, 1'b0, len);
    check("y_3_16", {8'd0, y_o}, 32'd31);
    repeat (5) @(negedge clk);
    check("y_hold", {8'd0, y_o}, 32'd31);

    run_op(8'd255, 8'd255, 1'b0, len);
    check("y_max", {8'd0, y_o}, 32'd16581390);
    run_op(8'd0, 8'd0, 1'b0, len);
    check("y_zero", {8'd0, y_o}, 32'd0);

    // A second start mid-operation with new operands must be ignored.
    start_i = 1'b1; a_i = 8'd2; b_i = 8'd9;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    start_i = 1'b1; a_i = 8'd7; b_i = 8'd100;
    @(negedge clk);
    start_i = 1'b0; a_i = 8'd99; b_i = 8'd1;
    wait_idle("ign_done");
    check("y_ign", {8'd0, y_o}, 32'd11);
    repeat (3) @(negedge clk);
    check("ign_no_restart", {31'd0, busy_o}, 32'd0);

    // Start held high: the model re-arms at every idle edge.
    start_i = 1'b1; a_i = 8'd5; b_i = 8'd30;
    repeat (40) @(negedge clk);
    start_i = 1'b0;
    wait_idle("held_done");
    check("y_held", {8'd0, y_o}, 32'd130);

    // Asynchronous reset mid-operation.
    start_i = 1'b1; a_i = 8'd10; b_i = 8'd50;
    @(negedge clk);
    start_i = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_y", {8'd0, y_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("post_rst_busy", {31'd0, busy_o}, 32'd0);
    check("post_rst_y", {8'd0, y_o}, 32'd0);

`ifdef FUNC_ACCEL_ZERO_SKIP_EN
    run_op(8'd0, 8'd200, 1'b0, len);
    check("zs_len", len, 32'd5);
    check("zs_y0", {8'd0, y_o}, 32'd14);
    run_op(8'd1, 8'd200, 1'b0, len);
    check("zs_len1", len, 32'd17);
    check("zs_y1", {8'd0, y_o}, 32'd15);
`endif

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 8'd0;
        1: ra = 8'd255;
        2: rb = 8'd0;
        3: rb = 8'd255;
        default: ;
      endcase
      run_op(ra, rb, 1'b1, len);
      check("rnd_y", {8'd0, y_o}, {8'd0, ref_y(ra, rb)});
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
